btn_conditioner: RTL

//  Parametrised multi-channel front-end for board push-buttons. It generates a divided sampling tick,

---
 rtl/btn_conditioner_pkg.sv | 21 ++
 rtl/btn_chan.sv | 131 +++++++++++++
 rtl/btn_conditioner.sv | 67 ++++++
 3 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner: channel FSM encoding and
// sizing of the per-channel repeat counter.
package btn_conditioner_pkg;

  // 2'd3 is never produced; the channel FSM treats it as idle.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHeld   = 2'd1,
    StRepeat = 2'd2
  } chan_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to hold the larger of the two repeat intervals without wrapping.
  function automatic int unsigned rep_cnt_width(input int unsigned dly, input int unsigned rate);
    return $clog2(max_u(dly, rate) + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: sample shift register, debounced level, press/release strobes and the
// hold-to-repeat state machine with its interval counter.
module btn_chan
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DebDepth   = 3,
  parameter int unsigned RepeatDly  = 64,
  parameter int unsigned RepeatRate = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic tick_d,
  input  logic btn,
  input  logic repeat_en,
  output logic level,
  output logic press_stb,
  output logic release_stb
);

  localparam int unsigned RepW = rep_cnt_width(RepeatDly, RepeatRate);
  localparam logic [RepW-1:0] DlyCnt  = RepW'(RepeatDly);
  localparam logic [RepW-1:0] RateCnt = RepW'(RepeatRate);

  logic [DebDepth-1:0] sr_q;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  chan_state_e         state_q, state_d;
  logic [RepW-1:0]     rep_cnt_q, rep_cnt_d;
  logic [RepW-1:0]     rep_inc;
  logic                rise, fall, rep_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (tick) begin
      sr_q <= {sr_q[DebDepth-2:0], btn};
    end
  end

  // Level decisions are taken the cycle after the sample lands in the shift register.
  assign rise    = tick_d & (&sr_q) & ~level_q;
  assign fall    = tick_d & ~(|sr_q) & level_q;
  assign rep_inc = rep_cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (tick_d) begin
      case (state_q)
        StHeld: begin
          if (fall) begin
            state_d   = StIdle;
            rep_cnt_d = '0;
          end else if (repeat_en) begin
            if (rep_inc == DlyCnt) begin
              rep_fire  = 1'b1;
              state_d   = StRepeat;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_inc;
            end
          end else begin
            rep_cnt_d = '0;
          end
        end
        StRepeat: begin
          if (fall) begin
            state_d   = StIdle;
            rep_cnt_d = '0;
          end else if (!repeat_en) begin
            state_d   = StHeld;
            rep_cnt_d = '0;
          end else if (rep_inc == RateCnt) begin
            rep_fire  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
        default: begin
          state_d   = rise ? StHeld : StIdle;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    level_d = level_q;
    if (rise) begin
      level_d = 1'b1;
    end else if (fall) begin
      level_d = 1'b0;
    end
    press_d   = rise | rep_fire;
    release_d = fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level       = level_q;
  assign press_stb   = press_q;
  assign release_stb = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: sampling-tick divider, per-channel debounce/repeat
// channels and a wrap-around press-event counter.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 3,
  parameter int unsigned DIV_WIDTH   = 17,
  parameter int unsigned DEB_DEPTH   = 3,
  parameter int unsigned REPEAT_DLY  = 64,
  parameter int unsigned REPEAT_RATE = 16,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   i_btn,
  input  logic [NUM_BTN-1:0]   i_repeat_en,
  output logic                 o_tick,
  output logic [NUM_BTN-1:0]   o_level,
  output logic [NUM_BTN-1:0]   o_press,
  output logic [NUM_BTN-1:0]   o_release,
  output logic                 o_any_press,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [DIV_WIDTH-1:0] div_q;
  logic                 tick_d_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      tick_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      div_q    <= div_q + 1'b1;
      tick_d_q <= o_tick;
      if (o_any_press) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_tick = &div_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_chan #(
      .DebDepth  (DEB_DEPTH),
      .RepeatDly (REPEAT_DLY),
      .RepeatRate(REPEAT_RATE)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick       (o_tick),
      .tick_d     (tick_d_q),
      .btn        (i_btn[g]),
      .repeat_en  (i_repeat_en[g]),
      .level      (o_level[g]),
      .press_stb  (o_press[g]),
      .release_stb(o_release[g])
    );
  end

  // Simultaneous presses on several channels count as one event.
  assign o_any_press = |o_press;
  assign o_cnt       = cnt_q;

endmodule
